multicycle_ctrl: RTL
====================

// Module: multicycle_ctrl
// PURPOSE
// - Multi-cycle control FSM for the MIPS-subset datapath (shared instr/data memory, one ALU, register file with V status flag).
// - Sequences FETCH/DECODE/EXEC/MEM/WB per instruction, including nandi, blezal, balv, brv, jalpc and jmxor.
// - Waits on a variable-latency memory ready handshake. Counts retired instructions. Traps on illegal opcode or memory timeout.
// PARAMETERS
// - MEM_TIMEOUT  15  max wait cycles on mem_ready before TRAP (counter width = $clog2(MEM_TIMEOUT+1))
// - CNT_W        32  width of instret counter
// PORTS
// - clk          in   1   rising-edge clock; the only clock
// - rst_n        in   1   asynchronous, active-low reset
// - opcode       in   6   IR[31:26]
// - funct        in   6   IR[5:0]
// - alu_zero     in   1   ALU zero flag
// - dataa_lez    in   1   rs <= 0 (signed)
// - status_v     in   1   datapath overflow status bit (status[0])
// - mem_ready    in   1   memory completes the access this cycle
// - pc_write     out  1   load PC from pc_source mux
// - ir_write     out  1   load IR from memory data
// - iord         out  1   0 = address from PC, 1 = ALU/xor address
// - mem_read     out  1   memory read request, held until mem_ready
// - mem_write    out  1   memory write request, held until mem_ready
// - reg_write    out  1   register-file write enable
// - reg_dst      out  2   0 rt, 1 rd, 2 r31
// - mem_to_reg   out  2   0 ALUOut, 1 MDR, 2 PC (link), 3 nand result
// - alu_src_a    out  1   0 PC, 1 rs
// - alu_src_b    out  2   0 rt, 1 const 4, 2 sign-ext imm, 3 sign-ext imm << 2
// - alu_op       out  2   0 add, 1 sub, 2 funct-decoded
// - pc_source    out  3   0 ALU result, 1 ALUOut (branch target), 2 J-target, 3 rs, 4 MDR
// - trap         out  1   sticky error flag
// - instret      out  CNT_W  retired-instruction count
// BEHAVIOUR
// - Reset (async, rst_n=0): state=FETCH, instret=0, trap=0, wait counter=0. All control outputs are combinational from state and default to 0.
// - FETCH: iord=0, mem_read=1, alu_src_a=0, alu_src_b=1, alu_op=0, pc_source=0. On mem_ready: ir_write=1, pc_write=1, next DECODE.
// - DECODE: alu_src_a=0, alu_src_b=3, alu_op=0 (precompute branch target into ALUOut). Dispatch on opcode/funct:
// -   R 0x00: funct brv 0x14 -> BRV; funct jmxor 0x23 -> JMX_ADDR; any other funct -> R_EXEC.
// -   lw 0x23 / sw 0x2B -> MEM_ADDR; beq 0x04 -> BEQ; nandi 0x10 -> NANDI; blezal 0x15 -> BLEZAL.
// -   balv 0x1A -> BALV; jalpc 0x1E -> JALPC; anything else -> TRAP.
// - R_EXEC (alu_src_a=1, alu_src_b=0, alu_op=2) -> R_WB (reg_dst=1, mem_to_reg=0, reg_write=1) -> FETCH.
// - MEM_ADDR (alu_src_a=1, alu_src_b=2, alu_op=0): lw -> MEM_RD, sw -> MEM_WR.
// - MEM_RD (iord=1, mem_read=1; on ready -> MEM_WB). MEM_WB: reg_dst=0, mem_to_reg=1, reg_write=1 -> FETCH.
// - MEM_WR (iord=1, mem_write=1; on ready -> FETCH).
// - BEQ: alu_src_a=1, alu_src_b=0, alu_op=1, pc_source=1; pc_write=alu_zero -> FETCH.
// - NANDI: reg_dst=0, mem_to_reg=3, reg_write=1 -> FETCH. The datapath nands rs with the zero-extended imm.
// - BLEZAL: if dataa_lez: pc_write=1, pc_source=1, reg_write=1, reg_dst=2, mem_to_reg=2 -> FETCH.
// - BALV: same as BLEZAL with condition status_v, pc_source=2. BRV: pc_write=status_v, pc_source=3 -> FETCH.
// - JALPC: reg_write=1, reg_dst=2, mem_to_reg=2, pc_write=1, pc_source=1 -> FETCH.
// - Link writes always use the PC already incremented in FETCH (PC+4).
// - JMX_ADDR (iord=1 selects rs^rt address) -> JMX_RD (mem_read=1, iord=1). On ready: pc_write=1, pc_source=4, reg_write=1, reg_dst=2, mem_to_reg=2 -> FETCH.
// - Wait counter: cleared on entry to FETCH, MEM_RD, MEM_WR and JMX_RD; increments each cycle without mem_ready.
// - If the counter reaches MEM_TIMEOUT with no mem_ready: go to TRAP and drop the request.
// - mem_ready arriving in the same cycle as the timeout wins, and the access completes.
// - TRAP: trap=1, all enables 0. Stays in TRAP until reset.
// - instret +1 on each transition back into FETCH from a non-FETCH state. Wraps modulo 2^CNT_W. Never counts in TRAP.
// - mem_read and mem_write are never both 1. pc_write and ir_write are only ever 1 in their listed states.
// - rst_n asserted mid-access: the request drops immediately (async). No write enable may pulse after reset.
// STRUCTURE
// - Package mc_pkg: state enum, opcode/funct localparams, and encodings for reg_dst, mem_to_reg, alu_src_b and pc_source.
// - One sub-module: mc_wait_timer (counter plus timeout compare), reused by all memory-wait states.
// TESTING
// - Reset with mem_ready=1 tied high; run add 0x00A53020 -> states FETCH,DECODE,R_EXEC,R_WB; reg_write only in R_WB; instret=1.
// - lw with mem_ready delayed 3 cycles in MEM_RD -> mem_read held 4 cycles; reg_write 1 cycle after ready.
// - blezal with dataa_lez=1 -> reg_dst=2, mem_to_reg=2, pc_source=1. With dataa_lez=0 -> no writes.
// - balv/brv with status_v=0 then 1 -> pc_write 0 then 1. jmxor -> pc_source=4 only on the ready cycle.
// - mem_ready never asserted in FETCH -> trap=1 after exactly 15 wait cycles; opcode 0x3F -> TRAP from DECODE.
// - rst_n pulsed low during MEM_WR -> mem_write=0 the same cycle; state=FETCH, instret=0 after release.

Source files
------------

// File: rtl/mc_pkg.sv
// Shared types and encodings for the multi-cycle MIPS-subset controller.
package mc_pkg;

  typedef enum logic [4:0] {
    FETCH, DECODE, R_EXEC, R_WB, MEM_ADDR, MEM_RD, MEM_WB, MEM_WR,
    BEQ, NANDI, BLEZAL, BALV, BRV, JALPC, JMX_ADDR, JMX_RD, TRAP
  } state_t;

  localparam logic [5:0] OP_RTYPE  = 6'h00;
  localparam logic [5:0] OP_BEQ    = 6'h04;
  localparam logic [5:0] OP_NANDI  = 6'h10;
  localparam logic [5:0] OP_BLEZAL = 6'h15;
  localparam logic [5:0] OP_BALV   = 6'h1A;
  localparam logic [5:0] OP_JALPC  = 6'h1E;
  localparam logic [5:0] OP_LW     = 6'h23;
  localparam logic [5:0] OP_SW     = 6'h2B;

  localparam logic [5:0] FN_BRV    = 6'h14;
  localparam logic [5:0] FN_JMXOR  = 6'h23;

  localparam logic [1:0] RD_RT  = 2'd0;
  localparam logic [1:0] RD_RD  = 2'd1;
  localparam logic [1:0] RD_R31 = 2'd2;

  localparam logic [1:0] MTR_ALUOUT = 2'd0;
  localparam logic [1:0] MTR_MDR    = 2'd1;
  localparam logic [1:0] MTR_PC     = 2'd2;
  localparam logic [1:0] MTR_NAND   = 2'd3;

  localparam logic [1:0] SRCB_RT     = 2'd0;
  localparam logic [1:0] SRCB_FOUR   = 2'd1;
  localparam logic [1:0] SRCB_IMM    = 2'd2;
  localparam logic [1:0] SRCB_IMM_SH = 2'd3;

  localparam logic [1:0] ALU_ADD   = 2'd0;
  localparam logic [1:0] ALU_SUB   = 2'd1;
  localparam logic [1:0] ALU_FUNCT = 2'd2;

  localparam logic [2:0] PCS_ALU    = 3'd0;
  localparam logic [2:0] PCS_ALUOUT = 3'd1;
  localparam logic [2:0] PCS_JUMP   = 3'd2;
  localparam logic [2:0] PCS_RS     = 3'd3;
  localparam logic [2:0] PCS_MDR    = 3'd4;

  function automatic logic is_wait_state(input state_t s);
    return s inside {FETCH, MEM_RD, MEM_WR, JMX_RD};
  endfunction

endpackage

// File: rtl/mc_wait_timer.sv
// Memory-wait counter: counts cycles spent waiting on ready, flags the last
// permitted wait cycle. Cleared whenever no wait is in progress.
module mc_wait_timer #(
  parameter int TIMEOUT = 15,
  parameter int W       = $clog2(TIMEOUT + 1)
) (
  input  logic clk,
  input  logic rst_n,
  input  logic active,
  input  logic ready,
  output logic timeout
);

  logic [W-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                cnt <= '0;
    else if (active && !ready) cnt <= cnt + 1'b1;
    else                       cnt <= '0;
  end

  // A ready in the final cycle still wins, so timeout is masked by ready.
  assign timeout = active && !ready && (cnt == W'(TIMEOUT - 1));

endmodule

// File: rtl/multicycle_ctrl.sv
// Multi-cycle control FSM for the MIPS-subset datapath with shared memory.
//
// state    | meaning
// FETCH    | read instruction at PC, PC <= PC+4
// DECODE   | precompute branch target, dispatch on opcode/funct
// R_EXEC   | ALU op on rs,rt       R_WB   | write rd
// MEM_ADDR | rs+imm address        MEM_RD | load wait   MEM_WB | write rt
// MEM_WR   | store wait            BEQ    | conditional branch
// NANDI    | write rs nand imm     BLEZAL/BALV/BRV/JALPC | branch/link
// JMX_ADDR | rs^rt address         JMX_RD | read jump target, link
// TRAP     | illegal op or memory timeout, held until reset
module multicycle_ctrl import mc_pkg::*; #(
  parameter int MEM_TIMEOUT = 15,
  parameter int CNT_W       = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [5:0]       opcode,
  input  logic [5:0]       funct,
  input  logic             alu_zero,
  input  logic             dataa_lez,
  input  logic             status_v,
  input  logic             mem_ready,
  output logic             pc_write,
  output logic             ir_write,
  output logic             iord,
  output logic             mem_read,
  output logic             mem_write,
  output logic             reg_write,
  output logic [1:0]       reg_dst,
  output logic [1:0]       mem_to_reg,
  output logic             alu_src_a,
  output logic [1:0]       alu_src_b,
  output logic [1:0]       alu_op,
  output logic [2:0]       pc_source,
  output logic             trap,
  output logic [CNT_W-1:0] instret
);

  state_t state, state_nxt;
  logic   timeout;

  mc_wait_timer #(.TIMEOUT(MEM_TIMEOUT)) u_timer (
    .clk    (clk),
    .rst_n  (rst_n),
    .active (is_wait_state(state)),
    .ready  (mem_ready),
    .timeout(timeout)
  );

  always_comb begin
    state_nxt = state;
    case (state)
      FETCH:    if (mem_ready) state_nxt = DECODE; else if (timeout) state_nxt = TRAP;
      DECODE: begin
        case (opcode)
          OP_RTYPE: begin
            if (funct == FN_BRV)        state_nxt = BRV;
            else if (funct == FN_JMXOR) state_nxt = JMX_ADDR;
            else                        state_nxt = R_EXEC;
          end
          OP_LW, OP_SW: state_nxt = MEM_ADDR;
          OP_BEQ:       state_nxt = BEQ;
          OP_NANDI:     state_nxt = NANDI;
          OP_BLEZAL:    state_nxt = BLEZAL;
          OP_BALV:      state_nxt = BALV;
          OP_JALPC:     state_nxt = JALPC;
          default:      state_nxt = TRAP;
        endcase
      end
      R_EXEC:   state_nxt = R_WB;
      MEM_ADDR: state_nxt = (opcode == OP_LW) ? MEM_RD : MEM_WR;
      MEM_RD:   if (mem_ready) state_nxt = MEM_WB; else if (timeout) state_nxt = TRAP;
      MEM_WR, JMX_RD:
                if (mem_ready) state_nxt = FETCH;  else if (timeout) state_nxt = TRAP;
      JMX_ADDR: state_nxt = JMX_RD;
      R_WB, MEM_WB, BEQ, NANDI, BLEZAL, BALV, BRV, JALPC:
                state_nxt = FETCH;
      TRAP:     state_nxt = TRAP;
      default:  state_nxt = TRAP;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= FETCH;
      instret <= '0;
    end else begin
      state <= state_nxt;
      if (state != FETCH && state_nxt == FETCH) instret <= instret + 1'b1;
    end
  end

  always_comb begin
    pc_write   = 1'b0;
    ir_write   = 1'b0;
    iord       = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    reg_write  = 1'b0;
    reg_dst    = RD_RT;
    mem_to_reg = MTR_ALUOUT;
    alu_src_a  = 1'b0;
    alu_src_b  = SRCB_RT;
    alu_op     = ALU_ADD;
    pc_source  = PCS_ALU;
    case (state)
      FETCH: begin
        mem_read  = 1'b1;
        alu_src_b = SRCB_FOUR;
        ir_write  = mem_ready;
        pc_write  = mem_ready;
      end
      DECODE:   alu_src_b = SRCB_IMM_SH;
      R_EXEC: begin
        alu_src_a = 1'b1;
        alu_op    = ALU_FUNCT;
      end
      R_WB: begin
        reg_dst   = RD_RD;
        reg_write = 1'b1;
      end
      MEM_ADDR: begin
        alu_src_a = 1'b1;
        alu_src_b = SRCB_IMM;
      end
      MEM_RD: begin
        iord     = 1'b1;
        mem_read = 1'b1;
      end
      MEM_WB: begin
        mem_to_reg = MTR_MDR;
        reg_write  = 1'b1;
      end
      MEM_WR: begin
        iord      = 1'b1;
        mem_write = 1'b1;
      end
      BEQ: begin
        alu_src_a = 1'b1;
        alu_op    = ALU_SUB;
        pc_source = PCS_ALUOUT;
        pc_write  = alu_zero;
      end
      NANDI: begin
        mem_to_reg = MTR_NAND;
        reg_write  = 1'b1;
      end
      BLEZAL, BALV, JALPC: begin
        if ((state == BLEZAL && dataa_lez) || (state == BALV && status_v) || state == JALPC) begin
          pc_write   = 1'b1;
          pc_source  = (state == BALV) ? PCS_JUMP : PCS_ALUOUT;
          reg_write  = 1'b1;
          reg_dst    = RD_R31;
          mem_to_reg = MTR_PC;
        end
      end
      BRV: begin
        pc_source = PCS_RS;
        pc_write  = status_v;
      end
      JMX_ADDR: iord = 1'b1;
      JMX_RD: begin
        iord     = 1'b1;
        mem_read = 1'b1;
        if (mem_ready) begin
          pc_write   = 1'b1;
          pc_source  = PCS_MDR;
          reg_write  = 1'b1;
          reg_dst    = RD_R31;
          mem_to_reg = MTR_PC;
        end
      end
      default: ;
    endcase
    // Write enables are held off while reset is asserted.
    pc_write  = pc_write  & rst_n;
    ir_write  = ir_write  & rst_n;
    reg_write = reg_write & rst_n;
    mem_write = mem_write & rst_n;
  end

  assign trap = (state == TRAP);

endmodule
